// File: rtl/fc_dai_filter_pkg.sv
// Shared types for the fuse-controller DAI write filter: FSM states,
// access-table entry layout and default register offsets.
package fc_dai_filter_pkg;

  // Table fields are sized for the widest supported bus; narrower buses zero-extend.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_USER_W = 64;

  localparam logic [11:0] DEF_WDATA0_OFF = 12'h010;
  localparam logic [11:0] DEF_ADDR_OFF   = 12'h00C;
  localparam logic [11:0] DEF_CMD_OFF    = 12'h008;

  typedef enum logic [3:0] {
    RESET_ST   = 4'd0,
    IDLE_ST    = 4'd1,
    DATA_W_ST  = 4'd2,
    COLLECT_ST = 4'd3,
    ADDR_W_ST  = 4'd4,
    CMD_AW_ST  = 4'd5,
    CHECK_ST   = 4'd6,
    CMD_W_ST   = 4'd7,
    DISCARD_ST = 4'd8
  } fc_dai_filt_state_e;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] lo;
    logic [MAX_ADDR_W-1:0] hi;
    logic [MAX_USER_W-1:0] user;
    logic                  en;
  } fc_dai_tbl_entry_t;

endpackage

// File: rtl/fc_dai_range_match.sv
// Combinational access-table lookup: an entry hits when enabled, the fuse
// address lies inside [lo, hi] and the user matches.
module fc_dai_range_match
  import fc_dai_filter_pkg::*;
#(
  parameter int NUM_RANGES = 8
) (
  input  fc_dai_tbl_entry_t [NUM_RANGES-1:0] tbl,
  input  logic [MAX_ADDR_W-1:0]              addr,
  input  logic [MAX_USER_W-1:0]              user,
  output logic                               allowed,
  output logic [NUM_RANGES-1:0]              match_oh
);

  logic [NUM_RANGES-1:0] hit;

  for (genvar i = 0; i < NUM_RANGES; i++) begin : g_ent
    assign hit[i] = tbl[i].en && (addr >= tbl[i].lo) && (addr <= tbl[i].hi) &&
                    (user == tbl[i].user);
  end

  // Lowest-index hit wins the one-hot.
  assign match_oh = hit & (~hit + NUM_RANGES'(1));
  assign allowed  = |hit;

endmodule

// File: rtl/fc_dai_write_filter.sv
// Snoops AXI writes into the fuse-controller DAI block, tracks the
// WDATA..ADDRESS..CMD sequence and requests a discard on a policy violation.
module fc_dai_write_filter
  import fc_dai_filter_pkg::*;
#(
  parameter int              NUM_WDATA   = 2,
  parameter int              NUM_RANGES  = 8,
  parameter int              ADDR_W      = 32,
  parameter int              USER_W      = 32,
  parameter int              OFF_W       = 12,
  parameter logic [OFF_W-1:0] WDATA0_OFF = OFF_W'(DEF_WDATA0_OFF),
  parameter logic [OFF_W-1:0] ADDR_OFF   = OFF_W'(DEF_ADDR_OFF),
  parameter logic [OFF_W-1:0] CMD_OFF    = OFF_W'(DEF_CMD_OFF),
  parameter int              TIMEOUT_CYC = 1024,
  parameter int              CNT_W       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         fc_init_done_i,
  input  logic                         awvalid_i,
  input  logic                         awready_i,
  input  logic [ADDR_W-1:0]            awaddr_i,
  input  logic [USER_W-1:0]            awuser_i,
  input  logic                         wvalid_i,
  input  logic                         wready_i,
  input  logic [31:0]                  wdata_i,
  input  logic [NUM_RANGES*ADDR_W-1:0] tbl_lo_i,
  input  logic [NUM_RANGES*ADDR_W-1:0] tbl_hi_i,
  input  logic [NUM_RANGES*USER_W-1:0] tbl_user_i,
  input  logic [NUM_RANGES-1:0]        tbl_en_i,
  input  logic                         discarded_fuse_write_i,
  output logic                         discard_fuse_write_o,
  output logic                         violation_o,
  output logic                         timeout_o,
  output logic [CNT_W-1:0]             violation_cnt_o,
  output logic [USER_W-1:0]            viol_user_o,
  output logic [ADDR_W-1:0]            viol_addr_o,
  output logic                         viol_valid_o,
  input  logic                         viol_clr_i
);

  localparam int IDX_W = (NUM_WDATA > 1) ? $clog2(NUM_WDATA) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  fc_dai_filt_state_e state;

  logic [NUM_WDATA-1:0][USER_W-1:0] slot_user;
  logic [NUM_WDATA-1:0]             slot_vld;
  logic [USER_W-1:0]                addr_user;
  logic [USER_W-1:0]                cmd_user;
  logic [ADDR_W-1:0]                fuse_addr;
  logic [TO_W-1:0]                  to_cnt;

  logic             aw_acc, w_acc;
  logic [OFF_W-1:0] off;
  logic             wd_any;
  logic [IDX_W-1:0] wd_idx;
  logic             is_cmd, is_addr;

  assign aw_acc  = awvalid_i & awready_i;
  assign w_acc   = wvalid_i & wready_i;
  assign off     = awaddr_i[OFF_W-1:0];
  assign is_cmd  = (off == CMD_OFF);
  assign is_addr = (off == ADDR_OFF);

  always_comb begin
    wd_any = 1'b0;
    wd_idx = '0;
    for (int k = 0; k < NUM_WDATA; k++) begin
      if (off == WDATA0_OFF + OFF_W'(4 * k)) begin
        wd_any = 1'b1;
        wd_idx = IDX_W'(k);
      end
    end
  end

  // Range lookup keys on the first data slot's user.
  fc_dai_tbl_entry_t [NUM_RANGES-1:0] tbl;
  logic                               allowed;
  logic [NUM_RANGES-1:0]              match_oh;

  always_comb begin
    for (int i = 0; i < NUM_RANGES; i++) begin
      tbl[i].lo   = MAX_ADDR_W'(tbl_lo_i[i*ADDR_W +: ADDR_W]);
      tbl[i].hi   = MAX_ADDR_W'(tbl_hi_i[i*ADDR_W +: ADDR_W]);
      tbl[i].user = MAX_USER_W'(tbl_user_i[i*USER_W +: USER_W]);
      tbl[i].en   = tbl_en_i[i];
    end
  end

  fc_dai_range_match #(
    .NUM_RANGES (NUM_RANGES)
  ) u_match (
    .tbl      (tbl),
    .addr     (MAX_ADDR_W'(fuse_addr)),
    .user     (MAX_USER_W'(slot_user[0])),
    .allowed  (allowed),
    .match_oh (match_oh)
  );

  logic same, pass;

  always_comb begin
    same = (addr_user == cmd_user);
    for (int k = 0; k < NUM_WDATA; k++)
      if (slot_vld[k] && (slot_user[k] != cmd_user)) same = 1'b0;
  end

  assign pass = allowed && (match_oh != '0) && same;

  logic timed, quiet, to_fire, enter_disc, clr_rec, legal;

  assign timed   = state inside {DATA_W_ST, COLLECT_ST, ADDR_W_ST, CMD_AW_ST, CMD_W_ST};
  assign quiet   = !aw_acc && !w_acc;
  assign to_fire = timed && quiet && (to_cnt == TO_MAX);
  assign legal   = state inside {RESET_ST, IDLE_ST, DATA_W_ST, COLLECT_ST, ADDR_W_ST,
                                 CMD_AW_ST, CHECK_ST, CMD_W_ST, DISCARD_ST};

  assign enter_disc = ((state == COLLECT_ST) && aw_acc && !wd_any && !is_addr && is_cmd) ||
                      ((state == CHECK_ST) && !pass);

  // Every path back to IDLE drops the partially collected sequence.
  assign clr_rec = to_fire || !legal ||
                   ((state == CMD_W_ST) && w_acc) ||
                   ((state == DISCARD_ST) && discarded_fuse_write_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                <= RESET_ST;
      slot_user            <= '0;
      slot_vld             <= '0;
      addr_user            <= '0;
      cmd_user             <= '0;
      fuse_addr            <= '0;
      to_cnt               <= '0;
      discard_fuse_write_o <= 1'b0;
      violation_o          <= 1'b0;
      timeout_o            <= 1'b0;
      violation_cnt_o      <= '0;
      viol_user_o          <= '0;
      viol_addr_o          <= '0;
      viol_valid_o         <= 1'b0;
    end else begin
      case (state)
        RESET_ST: if (fc_init_done_i) state <= IDLE_ST;
        IDLE_ST: begin
          if (aw_acc && wd_any) begin
            slot_user[wd_idx] <= awuser_i;
            slot_vld[wd_idx]  <= 1'b1;
            state             <= DATA_W_ST;
          end
        end
        // A W beat coincident with a new AW completes the pending AW.
        DATA_W_ST: if (w_acc) state <= COLLECT_ST;
        COLLECT_ST: begin
          if (aw_acc) begin
            if (wd_any) begin
              slot_user[wd_idx] <= awuser_i;
              slot_vld[wd_idx]  <= 1'b1;
              state             <= DATA_W_ST;
            end else if (is_addr) begin
              addr_user <= awuser_i;
              state     <= ADDR_W_ST;
            end else if (is_cmd) begin
              state <= DISCARD_ST;
            end
          end
        end
        ADDR_W_ST: begin
          if (w_acc) begin
            fuse_addr <= ADDR_W'(wdata_i);
            state     <= CMD_AW_ST;
          end
        end
        CMD_AW_ST: begin
          if (aw_acc && is_cmd) begin
            cmd_user <= awuser_i;
            state    <= CHECK_ST;
          end
        end
        CHECK_ST:   state <= pass ? CMD_W_ST : DISCARD_ST;
        CMD_W_ST:   if (w_acc) state <= IDLE_ST;
        DISCARD_ST: if (discarded_fuse_write_i) state <= IDLE_ST;
        default:    state <= IDLE_ST;
      endcase

      if (to_fire) state <= IDLE_ST;

      if (clr_rec) begin
        slot_user <= '0;
        slot_vld  <= '0;
        addr_user <= '0;
        cmd_user  <= '0;
        fuse_addr <= '0;
      end

      to_cnt <= (!timed || !quiet || to_fire) ? '0 : to_cnt + TO_W'(1);

      timeout_o            <= to_fire;
      violation_o          <= enter_disc;
      discard_fuse_write_o <= enter_disc ||
                              ((state == DISCARD_ST) && !discarded_fuse_write_i);

      if (enter_disc && (violation_cnt_o != '1))
        violation_cnt_o <= violation_cnt_o + CNT_W'(1);

      // Clear first so a same-cycle violation is captured into the fresh log.
      if (viol_clr_i) begin
        viol_valid_o <= 1'b0;
        viol_user_o  <= '0;
        viol_addr_o  <= '0;
      end
      if (enter_disc && (!viol_valid_o || viol_clr_i)) begin
        viol_valid_o <= 1'b1;
        viol_user_o  <= (state == COLLECT_ST) ? awuser_i : cmd_user;
        viol_addr_o  <= fuse_addr;
      end
    end
  end

endmodule

// File: tb/tb_fc_dai_write_filter.sv
// Directed bench for the DAI write filter: expectations are queued when a
// CMD is issued and compared when the filter responds.
module tb_fc_dai_write_filter;

  localparam int NR = 8;
  localparam int AW = 32;
  localparam int UW = 32;
  localparam int CW = 2;

  localparam logic [31:0] WD0 = 32'h010;
  localparam logic [31:0] WD1 = 32'h014;
  localparam logic [31:0] ADR = 32'h00C;
  localparam logic [31:0] CMD = 32'h008;

  logic              clk;
  logic              rst;
  logic              init_done;
  logic              awvalid, awready, wvalid, wready;
  logic [AW-1:0]     awaddr;
  logic [UW-1:0]     awuser;
  logic [31:0]       wdata;
  logic [NR*AW-1:0]  tbl_lo, tbl_hi;
  logic [NR*UW-1:0]  tbl_user;
  logic [NR-1:0]     tbl_en;
  logic              discarded;
  logic              discard, violation, timeout, viol_valid, viol_clr;
  logic [CW-1:0]     viol_cnt;
  logic [UW-1:0]     viol_user;
  logic [AW-1:0]     viol_addr;

  fc_dai_write_filter #(
    .CNT_W (CW)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .fc_init_done_i         (init_done),
    .awvalid_i              (awvalid),
    .awready_i              (awready),
    .awaddr_i               (awaddr),
    .awuser_i               (awuser),
    .wvalid_i               (wvalid),
    .wready_i               (wready),
    .wdata_i                (wdata),
    .tbl_lo_i               (tbl_lo),
    .tbl_hi_i               (tbl_hi),
    .tbl_user_i             (tbl_user),
    .tbl_en_i               (tbl_en),
    .discarded_fuse_write_i (discarded),
    .discard_fuse_write_o   (discard),
    .violation_o            (violation),
    .timeout_o              (timeout),
    .violation_cnt_o        (viol_cnt),
    .viol_user_o            (viol_user),
    .viol_addr_o            (viol_addr),
    .viol_valid_o           (viol_valid),
    .viol_clr_i             (viol_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          disc;
    logic [UW-1:0] vuser;
    logic [AW-1:0] vaddr;
    logic          vvalid;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [CW-1:0] m_cnt;
  logic          m_vv;
  logic [UW-1:0] m_vu;
  logic [AW-1:0] m_va;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [31:0] a, input logic [31:0] u);
    awvalid = 1'b1; awready = 1'b1; awaddr = a; awuser = u;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; awready = 1'b0; awaddr = '0; awuser = '0;
  endtask

  task automatic wb(input logic [31:0] d, input logic rdy);
    wvalid = 1'b1; wready = rdy; wdata = d;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wready = 1'b0; wdata = '0;
  endtask

  // Full sequence; the un-ready W beat carrying 0x80 must not be taken as the address.
  task automatic seq(input logic [31:0] u0, u1, ua, uc, addr);
    aw(WD0, u0); wb(32'hA5, 1'b1);
    aw(WD1, u1); wb(32'h5A, 1'b1);
    aw(ADR, ua); wb(32'h80, 1'b0); wb(addr, 1'b1);
    aw(CMD, uc);
  endtask

  task automatic push_exp(input logic disc, input logic clr, input logic [31:0] u,
                          input logic [31:0] a);
    exp_t e;
    if (clr) begin m_vv = 1'b0; m_vu = '0; m_va = '0; end
    if (disc) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (!m_vv) begin m_vv = 1'b1; m_vu = u; m_va = a; end
    end
    e.disc = disc; e.vuser = m_vu; e.vaddr = m_va; e.vvalid = m_vv; e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  // Called at the negedge right after the CMD AW was accepted.
  task automatic check_cmd(input int lat, input string tag);
    exp_t e;
    if (lat == 2) begin
      chk({tag, "_early"}, discard, 1'b0);
      @(negedge clk);
    end
    viol_clr = 1'b0;
    if (sbq.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_disc"}, discard, e.disc);
      chk({tag, "_viol"}, violation, e.disc);
      chk({tag, "_cnt"}, viol_cnt, e.cnt);
      chk({tag, "_vvalid"}, viol_valid, e.vvalid);
      chk({tag, "_vuser"}, viol_user, e.vuser);
      chk({tag, "_vaddr"}, viol_addr, e.vaddr);
      if (e.disc) begin
        @(negedge clk);
        chk({tag, "_pulse"}, violation, 1'b0);
        repeat (2) @(negedge clk);
        chk({tag, "_hold"}, discard, 1'b1);
        discarded = 1'b1;
        @(negedge clk);
        discarded = 1'b0;
        chk({tag, "_drop"}, discard, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    rst = 1'b1; init_done = 1'b0; viol_clr = 1'b0; discarded = 1'b0;
    awvalid = 1'b0; awready = 1'b0; awaddr = '0; awuser = '0;
    wvalid = 1'b0; wready = 1'b0; wdata = '0;
    tbl_lo = '0; tbl_hi = '0; tbl_user = '0; tbl_en = '0;
    tbl_lo[0*AW +: AW] = 32'h00;  tbl_hi[0*AW +: AW] = 32'h7F;  tbl_user[0*UW +: UW] = 32'h1; tbl_en[0] = 1'b1;
    tbl_lo[2*AW +: AW] = 32'h80;  tbl_hi[2*AW +: AW] = 32'hFF;  tbl_user[2*UW +: UW] = 32'h1; tbl_en[2] = 1'b0;
    tbl_lo[3*AW +: AW] = 32'h100; tbl_hi[3*AW +: AW] = 32'h1FF; tbl_user[3*UW +: UW] = 32'h3; tbl_en[3] = 1'b1;
    m_cnt = '0; m_vv = 1'b0; m_vu = '0; m_va = '0;

    repeat (3) @(negedge clk);
    chk("rst_disc", discard, 1'b0);
    chk("rst_viol", violation, 1'b0);
    chk("rst_to", timeout, 1'b0);
    chk("rst_cnt", viol_cnt, 2'd0);
    chk("rst_vvalid", viol_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    init_done = 1'b1;
    repeat (2) @(negedge clk);

    // Legal sequence
    seq(1, 1, 1, 1, 32'h40);
    push_exp(1'b0, 1'b0, 0, 0);
    check_cmd(2, "legal");
    wb(32'h1, 1'b1);

    // Foreign CMD user
    seq(1, 1, 1, 2, 32'h40);
    push_exp(1'b1, 1'b0, 2, 32'h40);
    check_cmd(2, "cmd_user");

    // Address only covered by a disabled entry
    seq(1, 1, 1, 1, 32'h80);
    push_exp(1'b1, 1'b0, 1, 32'h80);
    check_cmd(2, "out_range");

    // Matching entry disabled
    tbl_en[0] = 1'b0;
    seq(1, 1, 1, 1, 32'h40);
    push_exp(1'b1, 1'b0, 1, 32'h40);
    check_cmd(2, "entry_dis");
    tbl_en[0] = 1'b1;

    // Timeout after WDATA_0 with no further traffic
    aw(WD0, 1);
    n = 0; seen = 1'b0;
    while (n < 1200 && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (timeout) seen = 1'b1;
    end
    chk("timeout_seen", seen, 1'b1);
    chk("timeout_cycles", n, 1024);
    chk("timeout_nodisc", discard, 1'b0);
    @(negedge clk);
    chk("timeout_pulse", timeout, 1'b0);
    chk("timeout_cnt", viol_cnt, m_cnt);
    // Back in IDLE: a stray W then CMD must not form a sequence
    wb(32'h0, 1'b1);
    aw(CMD, 1);
    push_exp(1'b0, 1'b0, 0, 0);
    check_cmd(2, "post_to");

    // Clear the log on its own
    viol_clr = 1'b1;
    @(negedge clk);
    viol_clr = 1'b0;
    m_vv = 1'b0; m_vu = '0; m_va = '0;
    chk("clr_vvalid", viol_valid, 1'b0);
    chk("clr_vuser", viol_user, 32'h0);

    // CMD straight after WDATA, no ADDRESS
    aw(WD0, 5); wb(32'h0, 1'b1);
    aw(CMD, 5);
    push_exp(1'b1, 1'b0, 5, 0);
    check_cmd(1, "order");

    // Clear coincident with a new violation keeps the new one
    seq(1, 1, 1, 7, 32'h44);
    viol_clr = 1'b1;
    push_exp(1'b1, 1'b1, 7, 32'h44);
    check_cmd(2, "clr_viol");

    // Reset in the middle of a sequence
    aw(WD0, 1); wb(32'h0, 1'b1); aw(ADR, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_disc", discard, 1'b0);
    chk("mrst_viol", violation, 1'b0);
    chk("mrst_to", timeout, 1'b0);
    chk("mrst_cnt", viol_cnt, 2'd0);
    chk("mrst_vvalid", viol_valid, 1'b0);
    chk("mrst_vuser", viol_user, 32'h0);
    chk("mrst_vaddr", viol_addr, 32'h0);
    rst = 1'b0;
    m_cnt = '0; m_vv = 1'b0; m_vu = '0; m_va = '0;
    repeat (2) @(negedge clk);

    seq(1, 1, 1, 1, 32'h7F);
    push_exp(1'b0, 1'b0, 0, 0);
    check_cmd(2, "legal2");
    wb(32'h1, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
